// File: rtl/muldiv_sequencer_pkg.sv
// Shared CPU types for the RV32M multiply/divide sequencer:
// op encodings (funct3), FSM states and M-extension decode constants.
package cpu_types_pkg;

    localparam int XLEN = 32;
    typedef logic [XLEN-1:0] word_t;

    localparam logic [6:0] OP_MULDIV     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    function automatic logic rs1_signed(input muldiv_op_t op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic rs2_signed(input muldiv_op_t op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> multiply/divide sequencer handshake bundle.
// master = execute datapath, slave = sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] rdat1;
    logic [WIDTH-1:0] dat2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, flush, funct3, rdat1, dat2,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, funct3, rdat1, dat2,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-divide step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    assign w_shifted = {i_rem, i_bit};
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    // Partial remainder stays below the divisor, so the difference MSB is the borrow.
    assign o_qbit    = ~w_diff[WIDTH];
    assign o_rem     = o_qbit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module muldiv_sequencer
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               CLK,
    input  logic               nRST,
    muldiv_sequencer_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    muldiv_state_t      r_state;
    muldiv_state_t      w_state_next;
    muldiv_op_t         r_op;
    muldiv_op_t         w_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_result;
    logic               r_neg;
    logic               r_neg_rem;

    logic               w_load;
    logic               w_step;
    logic               w_write;
    logic               w_last;
    logic [WIDTH-1:0]   w_result_next;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [WIDTH-1:0]   w_special;

    logic [WIDTH-1:0]   w_div_rem;
    logic               w_div_qbit;
    logic [2*WIDTH-1:0] w_div_acc;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rmd;
    logic [WIDTH-1:0]   w_iter_result;

    assign w_op    = muldiv_op_t'(bus.funct3);
    assign w_a_neg = rs1_signed(w_op) & bus.rdat1[WIDTH-1];
    assign w_b_neg = rs2_signed(w_op) & bus.dat2[WIDTH-1];
    assign w_a_mag = w_a_neg ? -bus.rdat1 : bus.rdat1;
    assign w_b_mag = w_b_neg ? -bus.dat2  : bus.dat2;

    assign w_div_zero = (bus.dat2 == '0);
    assign w_div_ovf  = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                        (bus.rdat1 == {1'b1, {(WIDTH-1){1'b0}}}) &&
                        (bus.dat2 == '1);
    // funct3[1] selects remainder for DIV-class ops.
    always_comb begin
        w_special = '0;
        if (w_div_zero)
            w_special = bus.funct3[1] ? bus.rdat1 : '1;
        else
            w_special = bus.funct3[1] ? '0 : bus.rdat1;
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_divisor (r_opnd),
        .i_bit     (r_acc[WIDTH-1]),
        .o_rem     (w_div_rem),
        .o_qbit    (w_div_qbit)
    );
    assign w_div_acc = {w_div_rem, r_acc[WIDTH-2:0], w_div_qbit};

`ifdef MULDIV_FAST_MUL_EN
    logic signed [WIDTH:0]     w_fa;
    logic signed [WIDTH:0]     w_fb;
    logic signed [2*WIDTH+1:0] w_fprod;
    logic [WIDTH-1:0]          w_fast_result;

    assign w_fa          = $signed({w_a_neg, bus.rdat1});
    assign w_fb          = $signed({w_b_neg, bus.dat2});
    assign w_fprod       = $signed({{(WIDTH+1){w_fa[WIDTH]}}, w_fa}) *
                           $signed({{(WIDTH+1){w_fb[WIDTH]}}, w_fb});
    assign w_fast_result = (w_op == MD_MUL) ? w_fprod[WIDTH-1:0] : w_fprod[2*WIDTH-1:WIDTH];
    assign w_acc_step    = w_div_acc;
`else
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [2*WIDTH-1:0] w_prod;

    // Accumulator holds {partial product, unconsumed multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_acc  = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_acc_step = (r_state == ST_DIV) ? w_div_acc : w_mul_acc;
    assign w_prod     = r_neg ? -w_acc_step : w_acc_step;
`endif

    assign w_quo = w_acc_step[WIDTH-1:0];
    assign w_rmd = w_acc_step[2*WIDTH-1:WIDTH];

    always_comb begin
        w_iter_result = r_op[1] ? (r_neg_rem ? -w_rmd : w_rmd) : (r_neg ? -w_quo : w_quo);
`ifndef MULDIV_FAST_MUL_EN
        if (r_state == ST_MUL)
            w_iter_result = (r_op == MD_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
`endif
    end

    assign w_last = (r_cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_load        = 1'b0;
        w_step        = 1'b0;
        w_write       = 1'b0;
        w_result_next = r_result;
        bus.busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    bus.busy = 1'b1;
                    if (!bus.funct3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                        w_write       = 1'b1;
                        w_result_next = w_fast_result;
                        w_state_next  = ST_DONE;
`else
                        w_load        = 1'b1;
                        w_state_next  = ST_MUL;
`endif
                    end else if (w_div_zero || w_div_ovf) begin
                        w_write       = 1'b1;
                        w_result_next = w_special;
                        w_state_next  = ST_DONE;
                    end else begin
                        w_load        = 1'b1;
                        w_state_next  = ST_DIV;
                    end
                end
            end
`ifndef MULDIV_FAST_MUL_EN
            ST_MUL,
`endif
            ST_DIV: begin
                bus.busy = 1'b1;
                w_step   = 1'b1;
                if (w_last) begin
                    w_write       = 1'b1;
                    w_result_next = w_iter_result;
                    w_state_next  = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (bus.flush) begin
            w_state_next = ST_IDLE;
            w_step       = 1'b0;
            w_write      = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_op      <= MD_MUL;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_result  <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            if (w_load) begin
                r_op      <= w_op;
                r_neg     <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
                r_cnt     <= '0;
                if (bus.funct3[2]) begin
                    r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                    r_opnd <= w_b_mag;
                end else begin
                    r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                    r_opnd <= w_a_mag;
                end
            end else if (w_step) begin
                r_acc <= w_acc_step;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (bus.flush)
                r_cnt <= '0;
            if (w_write)
                r_result <= w_result_next;
        end
    end

    assign bus.done   = (r_state == ST_DONE);
    assign bus.result = r_result;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle RV32M controller for the execute stage. It accepts a multiply/divide op from the execute datapath (rs1, rs2, funct3), runs an iterative shift-add multiply or restoring divide, and stalls the pipeline through `busy` until the result is ready. `done` pulses when `result` is valid. The execute ALU output mux selects `result` in that cycle.

## Interface
- Parameters
  - `WIDTH`, 32: operand and result width; equals `word_t`.
  - `CNT_W`, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.
- Ports
  - Clocking and reset: one clock; reset is asynchronous and active-low.
  - `CLK` in 1: clock, rising edge.
  - `nRST` in 1: asynchronous, active-low reset.
  - `start` in 1: execute holds a valid M-op (opcode 0110011, funct7 0000001).
  - `flush` in 1: squash the in-flight op (branch or jump redirect).
  - `funct3` in 3: M-op select.
  - `rdat1` in WIDTH: rs1.
  - `dat2` in WIDTH: rs2.
  - `busy` out 1: pipeline stall request.
  - `done` out 1: one-cycle pulse; `result` is valid.
  - `result` out WIDTH: registered result, held until the next completion.

## Operation
- States are IDLE, MUL, DIV, DONE.
- IDLE:
  - `start & ~flush` latches operands and funct3.
  - funct3[2]=0 goes to MUL. funct3[2]=1 goes to DIV, or directly to DONE for a special case.
- Signed handling:
  - Operands are converted to magnitudes at the latch:
    - MUL/MULH/DIV/REM: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MULHU/DIVU/REMU: both unsigned.
  - The sign is applied when the result is written in the final step.
- MUL:
  - 64-bit accumulator.
  - One shift-add per cycle for WIDTH cycles.
  - MUL returns low word. MULH, MULHSU and MULHU return high word.
- DIV:
  - Restoring shift-subtract, one quotient bit per cycle for WIDTH cycles.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder takes the sign of rs1.
- Special cases, resolved in IDLE with no iteration:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = rs1.
  - Signed DIV 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- DONE:
  - `done`=1 for exactly one cycle, then return to IDLE unconditionally.
  - `start` is ignored in DONE.
- `busy` = (state ∈ {MUL, DIV}) | (state==IDLE & start & ~flush). It is combinational, so the pipeline stalls in the issue cycle.
- `flush` from any state forces IDLE on the next edge:
  - no `done` pulse,
  - `result` unchanged,
  - counter cleared.
- Reset values: state IDLE, `result`=0, `done`=0, `busy`=0 (start low), counter 0, accumulator 0.
- Reset mid-operation aborts immediately, with no `done`.

## Timing
- `start` is sampled at edge 0.
- Iterative ops:
  - MUL/DIV occupy cycles 1..WIDTH.
  - DONE is in cycle WIDTH+1 (33).
  - Total latency is 33 cycles from the start edge to the `done` cycle.
- Special-case divides, and multiplies under FAST_MUL: DONE in cycle 1.
- `busy` is high from cycle 0 through the last iteration cycle. It is low in DONE so the pipeline advances on the `done` edge.
- The counter counts 0..WIDTH-1 and compares on the terminal value. There is no wrap.

## Configuration
- `MULDIV_FAST_MUL_EN`:
  - Defined: multiplies compute in one cycle with a combinational 64-bit product, so IDLE goes to DONE and latency is 1. The MUL state is not synthesised.
  - Undefined: iterative 32-cycle multiply. Divide is always iterative.

## Structure
- Shared package `cpu_types_pkg`:
  - `muldiv_op_t` enum for funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - `muldiv_state_t`.
  - Constants `OP_MULDIV`=7'b0110011 and `FUNCT7_MULDIV`=7'b0000001.
- One sub-module, `div_step`: combinational restoring-divide step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: next remainder, quotient bit.

## Test plan
- MUL, 7 × 6: `busy` high in cycles 0–32, `done` in cycle 33, `result` = 42. With `MULDIV_FAST_MUL_EN`, `done` in cycle 1.
- MULH, 0x80000000 × 0x80000000 → 0x40000000. MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV, −7 / 2 → 0xFFFFFFFD. REM, −7 / 2 → 0xFFFFFFFF. Both complete at cycle 33.
- DIVU, 5 / 0 → 0xFFFFFFFF. REMU, 5 / 0 → 5. DIV, 0x80000000 / 0xFFFFFFFF → 0x80000000. All have `done` in cycle 1.
- DIV 100 / 3 with `flush` at cycle 10: IDLE next cycle, `busy`=0, no `done`, `result` keeps its prior value. An immediate new MUL 3 × 3 yields 9.
- `nRST` asserted at cycle 15 of a divide: all outputs reset asynchronously, no `done` after release.
